// File: rtl/trng_frame_packer.sv
// trng_frame_packer: gathers serial entropy bits into a frame, launches it to the
// SPI master with a one-cycle start pulse, holds the frame until finish, then waits
// out a hold-off gap. A WAIT timeout abandons a hung transfer (sticky flag).
// Optional build macro TRNG_SEQ_NUM_EN: the top 8 frame bits carry frame_cnt[7:0]
// and the collector fills only DATA_WIDTH-8 bits.
module trng_frame_packer #(
    parameter int unsigned DATA_WIDTH     = 96,
    parameter int unsigned HOLDOFF_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  rnd_bit,
    input  logic                  rnd_valid,
    input  logic                  finish,
    output logic                  start,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  busy,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           drop_cnt,
    output logic                  timeout_err
);

`ifdef TRNG_SEQ_NUM_EN
    localparam int unsigned FILL = DATA_WIDTH - 8;
`else
    localparam int unsigned FILL = DATA_WIDTH;
`endif
    localparam int unsigned CW   = $clog2(DATA_WIDTH + 1);
    localparam int unsigned TMAX = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES
                                                                      : HOLDOFF_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] CCNT_FULL = CW'(FILL);
    localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_HOLD    = TW'(HOLDOFF_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [FILL-1:0] col;
    logic [CW-1:0]   ccnt;
    logic [TW-1:0]   timer;
    logic            full;
    logic            in_load;
    logic            bit_in;
    logic            drop;
    logic            timed_out;

    assign full      = (ccnt == CCNT_FULL);
    assign in_load   = (state == S_LOAD);
    assign bit_in    = enable & rnd_valid;
    // A full collector in LOAD is being emptied, so that bit is not a drop.
    assign drop      = bit_in & full & ~in_load;
    assign timed_out = (state == S_WAIT) & ~finish & (timer == T_TIMEOUT);

    assign start = (state == S_START);
    assign busy  = (state != S_IDLE);

    // Collector: shift bits in LSB-first; LOAD empties it and may take bit 0 at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col  <= '0;
            ccnt <= '0;
        end else if (in_load) begin
            ccnt <= bit_in ? CW'(1) : '0;
            if (bit_in) begin
                col[0] <= rnd_bit;
            end
        end else if (bit_in && !full) begin
            col[ccnt] <= rnd_bit;
            ccnt      <= ccnt + CW'(1);
        end
    end

    // Sender next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (enable && full) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (finish || timer == T_TIMEOUT) state_nxt = S_GAP;
            S_GAP:   if (timer == T_HOLD) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and shared WAIT/GAP timer (restarts at each phase entry).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_START: timer <= '0;
                S_WAIT:  timer <= (finish || timer == T_TIMEOUT) ? '0 : timer + TW'(1);
                S_GAP:   timer <= timer + TW'(1);
                default: timer <= '0;
            endcase
        end
    end

    // Frame register: written only in LOAD, so it is stable through WAIT and GAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_o <= '0;
        end else if (in_load) begin
`ifdef TRNG_SEQ_NUM_EN
            data_o <= {frame_cnt[7:0], col};
`else
            data_o <= col;
`endif
        end
    end

    // Statistics: wrapping frame count, saturating drop count, sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            drop_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_WAIT && finish) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trng_frame_packer.sv
// Bench for trng_frame_packer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_trng_frame_packer;
    localparam int DW   = 96;
    localparam int HOLD = 16;
    localparam int TMO  = 4096;
`ifdef TRNG_SEQ_NUM_EN
    localparam int FILL = DW - 8;
`else
    localparam int FILL = DW;
`endif
    localparam int P_IDLE = 0, P_LOAD = 1, P_START = 2, P_WAIT = 3, P_GAP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          rnd_bit = 1'b0;
    logic          rnd_valid = 1'b0;
    logic          finish = 1'b0;
    logic          start;
    logic          busy;
    logic          timeout_err;
    logic [DW-1:0] data_o;
    logic [15:0]   frame_cnt;
    logic [15:0]   drop_cnt;

    int n_checks = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    trng_frame_packer #(
        .DATA_WIDTH     (DW),
        .HOLDOFF_CYCLES (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rnd_bit     (rnd_bit),
        .rnd_valid   (rnd_valid),
        .finish      (finish),
        .start       (start),
        .data_o      (data_o),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .drop_cnt    (drop_cnt),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: collector as a bit queue, sender as spec-level phases.
    bit            mq[$];
    int            m_ph = P_IDLE;
    int            m_wait = 0;
    int            m_gap = 0;
    logic [DW-1:0] m_data = '0;
    logic [15:0]   m_frames = '0;
    logic [15:0]   m_drops = '0;
    logic          m_terr = 1'b0;

    always @(posedge clk) begin
        int  ph_now;
        bit  was_full;
        if (!rst_n) begin
            mq.delete();
            m_ph = P_IDLE; m_data = '0; m_frames = '0; m_drops = '0; m_terr = 1'b0;
            m_wait = 0; m_gap = 0;
        end else begin
            ph_now   = m_ph;
            was_full = (mq.size() == FILL);
            if (ph_now == P_LOAD) begin
                m_data = '0;
                foreach (mq[i]) m_data[i] = mq[i];
`ifdef TRNG_SEQ_NUM_EN
                m_data[DW-1 -: 8] = m_frames[7:0];
`endif
                mq.delete();
                if (enable && rnd_valid) mq.push_back(rnd_bit);
            end else if (enable && rnd_valid) begin
                if (!was_full) mq.push_back(rnd_bit);
                else if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            end
            case (ph_now)
                P_IDLE:  if (enable && was_full) m_ph = P_LOAD;
                P_LOAD:  m_ph = P_START;
                P_START: begin m_ph = P_WAIT; m_wait = 0; end
                P_WAIT: begin
                    if (finish) begin
                        m_frames = m_frames + 16'd1; m_ph = P_GAP; m_gap = 0;
                    end else if (m_wait == TMO - 1) begin
                        m_terr = 1'b1; m_ph = P_GAP; m_gap = 0;
                    end else begin
                        m_wait++;
                    end
                end
                P_GAP: begin
                    if (m_gap == HOLD - 1) m_ph = P_IDLE;
                    else m_gap++;
                end
                default: m_ph = P_IDLE;
            endcase
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("m_start", DW'(start), DW'(m_ph == P_START));
            chk("m_busy", DW'(busy), DW'(m_ph != P_IDLE));
            chk("m_data", data_o, m_data);
            chk("m_frame_cnt", DW'(frame_cnt), DW'(m_frames));
            chk("m_drop_cnt", DW'(drop_cnt), DW'(m_drops));
            chk("m_timeout_err", DW'(timeout_err), DW'(m_terr));
            chk("m_ccnt", DW'(dut.ccnt), DW'(mq.size()));
        end
    end

    task automatic step();
        @(negedge clk);
        rnd_valid = 1'b0;
        finish    = 1'b0;
    endtask

    task automatic feed(input int n, input bit alt);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            finish    = 1'b0;
            rnd_valid = 1'b1;
            rnd_bit   = alt ? i[0] : 1'($urandom);
        end
    endtask

    task automatic wait_start(input int max);
        bit seen = 1'b0;
        for (int k = 0; k < max && !seen; k++) begin
            step();
            seen = start;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_start: got no start, required start within %0d cycles", max);
        end
    endtask

    task automatic wait_idle(input int max);
        bit idle = 1'b0;
        for (int k = 0; k < max && !idle; k++) begin
            step();
            idle = !busy;
        end
        n_checks++;
        if (!idle) begin
            n_fail++;
            $display("FAIL wait_idle: busy still 1, required 0 within %0d cycles", max);
        end
    endtask

    task automatic pulse_finish();
        @(negedge clk);
        rnd_valid = 1'b0;
        finish    = 1'b1;
    endtask

    bit            rec[$];
    logic [DW-1:0] held;
    logic [DW-1:0] exp2;
    logic [DW-1:0] exp1;

    initial begin
        int since;
        int nst;
        int nstart;
        bit done;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        checking = 1'b1;
        chk("rst_start", DW'(start), '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_data", data_o, '0);
        chk("rst_frames", DW'(frame_cnt), '0);
        chk("rst_drops", DW'(drop_cnt), '0);
        chk("rst_terr", DW'(timeout_err), '0);
        chk("rst_ccnt", DW'(dut.ccnt), '0);
        enable = 1'b1;

        // Test 1: alternating pattern, start latency, finish, gap
`ifdef TRNG_SEQ_NUM_EN
        exp1 = {8'h00, 88'hAA_AAAA_AAAA_AAAA_AAAA_AAAA};
`else
        exp1 = 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
`endif
        feed(FILL, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("t1_start_lat", DW'(start), DW'(k == 3));
            if (k == 3) chk("t1_data", data_o, exp1);
        end
        repeat (999) step();
        pulse_finish();
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k == 1) chk("t1_frames", DW'(frame_cnt), DW'(1));
            if (k == 16) chk("t1_busy_gap", DW'(busy), DW'(1));
            if (k == 17) chk("t1_busy_idle", DW'(busy), DW'(0));
        end

        // Test 2: continuous valid bits, finish 200 cycles after each start
        since = -1; nst = 0; done = 1'b0;
        for (int j = 0; j < 2000 && !done; j++) begin
            @(negedge clk);
            if (start) begin
                since = 0; nst++; held = data_o;
`ifdef TRNG_SEQ_NUM_EN
                if (nst == 1) chk("t2_seq1", DW'(data_o[DW-1 -: 8]), DW'(8'h01));
`endif
                if (nst == 2) begin
                    exp2 = '0;
                    for (int i = 0; i < FILL; i++) exp2[i] = rec[FILL + 1 + i];
`ifdef TRNG_SEQ_NUM_EN
                    exp2[DW-1 -: 8] = 8'h02;
`endif
                    chk("t2_frame2_bits", data_o, exp2);
                end
            end else if (since >= 0) begin
                since++;
            end
            if (since == 200) begin
                chk("t2_hold", data_o, held);
                finish = 1'b1;
                since  = -1;
            end else begin
                finish = 1'b0;
            end
            rnd_valid = (j < 400);
            rnd_bit   = 1'($urandom);
            if (j < 400) rec.push_back(rnd_bit);
            if (j == 400) begin
                chk("t2_frames", DW'(frame_cnt), DW'(2));
`ifndef TRNG_SEQ_NUM_EN
                chk("t2_drops", DW'(drop_cnt), DW'(124));
`endif
            end
            if (j >= 400 && nst == 2 && finish) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL t2_done: got %0d starts, required 2 completed transfers", nst);
        end
        wait_idle(40);
        chk("t2_frames_end", DW'(frame_cnt), DW'(3));

        // Test 3: timeout with no finish
        feed(FILL - mq.size(), 1'b0);
        wait_start(5);
        for (int k = 1; k <= 4113; k++) begin
            step();
            if (k == 4096) chk("t3_terr_before", DW'(timeout_err), DW'(0));
            if (k == 4097) begin
                chk("t3_terr_set", DW'(timeout_err), DW'(1));
                chk("t3_frames", DW'(frame_cnt), DW'(3));
            end
            if (k == 4112) chk("t3_busy_gap", DW'(busy), DW'(1));
            if (k == 4113) chk("t3_busy_idle", DW'(busy), DW'(0));
        end
        feed(FILL, 1'b0);
        wait_start(5);
        repeat (10) step();
        pulse_finish();
        wait_idle(30);
        chk("t3_frames_next", DW'(frame_cnt), DW'(4));
        chk("t3_terr_sticky", DW'(timeout_err), DW'(1));

        // Test 4: reset mid-WAIT with 50 bits collected
        feed(FILL, 1'b0);
        wait_start(5);
        feed(50, 1'b0);
        @(negedge clk);
        rnd_valid = 1'b0;
        chk("t4_ccnt_pre", DW'(dut.ccnt), DW'(50));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t4_start", DW'(start), '0);
        chk("t4_busy", DW'(busy), '0);
        chk("t4_data", data_o, '0);
        chk("t4_frames", DW'(frame_cnt), '0);
        chk("t4_drops", DW'(drop_cnt), '0);
        chk("t4_terr", DW'(timeout_err), '0);
        chk("t4_ccnt", DW'(dut.ccnt), '0);
        pulse_finish();
        step();
        step();
        chk("t4_spurious_frames", DW'(frame_cnt), '0);
        chk("t4_spurious_busy", DW'(busy), '0);

        // Test 5: drop enable in WAIT with 40 bits collected
        feed(FILL, 1'b0);
        wait_start(5);
        feed(40, 1'b0);
        @(negedge clk);
        rnd_valid = 1'b0;
        enable    = 1'b0;
        repeat (20) step();
        pulse_finish();
        step();
        chk("t5_frames", DW'(frame_cnt), DW'(1));
        nstart = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            finish    = 1'b0;
            rnd_valid = 1'b1;
            rnd_bit   = 1'($urandom);
            if (start) nstart++;
        end
        step();
        chk("t5_no_start", DW'(nstart), '0);
        chk("t5_ccnt_kept", DW'(dut.ccnt), DW'(40));
        chk("t5_no_drops", DW'(drop_cnt), '0);
        enable = 1'b1;
        feed(FILL - 40, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("t5_start_lat", DW'(start), DW'(k == 3));
        end
        repeat (5) step();
        pulse_finish();
        wait_idle(30);
        chk("t5_frames_end", DW'(frame_cnt), DW'(2));

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/trng_frame_packer.md
Name: trng_frame_packer

Overview:
- Upstream stage of the 96-bit SPI master in the TRNG path.
- Collects serial random bits from the entropy source into a DATA_WIDTH-bit frame and double-buffers it.
- Pulses `start` to the SPI master and holds `data_o` stable until the master's `finish` pulse.
- Enforces a minimum inter-frame gap, detects a hung transfer by timeout, and keeps frame/drop statistics.

Parameters:
- DATA_WIDTH, 96: frame width; must match the SPI master; bit 0 is shifted out first.
- HOLDOFF_CYCLES, 16: clk cycles spent in GAP after `finish` before the next launch; must be ≥1.
- TIMEOUT_CYCLES, 4096: maximum clk cycles in WAIT before the transfer is abandoned.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst_n, input, 1: synchronous active-low reset.
- enable, input, 1: 1 = collect and launch frames.
- rnd_bit, input, 1: random bit from the entropy source.
- rnd_valid, input, 1: `rnd_bit` is valid this cycle.
- finish, input, 1: one-cycle done pulse from the SPI master.
- start, output, 1: one-cycle launch pulse to the SPI master.
- data_o, output, DATA_WIDTH: frame to the SPI master `data_i`.
- busy, output, 1: sender FSM not in IDLE.
- frame_cnt, output, 16: completed frames; wraps 0xFFFF→0.
- drop_cnt, output, 16: random bits discarded because the collector was full; saturates at 0xFFFF.
- timeout_err, output, 1: sticky; set on timeout; cleared only by reset.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst_n). All state is cleared on any clk edge with rst_n=0, including mid-frame.
  - Reset values: start=0, data_o=0, busy=0, frame_cnt=0, drop_cnt=0, timeout_err=0, FSM=IDLE, collector empty.
- Collector:
  - Holds a DATA_WIDTH shift register `col` and a 7-bit count `ccnt` (0..DATA_WIDTH).
  - On enable & rnd_valid & ccnt<DATA_WIDTH: col[ccnt]<=rnd_bit, ccnt++.
  - On enable & rnd_valid & ccnt==DATA_WIDTH and no transfer this cycle: drop_cnt++, saturating.
  - With enable=0, rnd_valid is ignored: no capture and no drop count.
- Sender FSM (IDLE, LOAD, START, WAIT, GAP):
  - IDLE: if enable & ccnt==DATA_WIDTH, go to LOAD.
  - LOAD:
    - data_o<=col and ccnt<=0.
    - If rnd_valid is high the same cycle, that bit is captured into col[0] and ccnt becomes 1. It is not counted as a drop.
    - Next state: START.
  - START: start=1 for exactly this cycle. Next state: WAIT. Reset the timeout counter.
  - WAIT:
    - On `finish`: frame_cnt++, go to GAP.
    - Else if the timer reaches TIMEOUT_CYCLES-1: timeout_err<=1, go to GAP with no frame_cnt increment.
  - GAP: count HOLDOFF_CYCLES cycles, then go to IDLE.
- `data_o` changes only in LOAD. It is stable from the START cycle through the `finish` cycle and GAP.
- A `finish` pulse outside WAIT is ignored.
- Latency: the last frame bit captured at cycle N gives LOAD at N+2 and `start` at N+3.
- enable deasserted mid-transfer: the current frame completes (WAIT/GAP proceed normally). No new LOAD occurs while enable=0. The partial collector is kept.
- busy = (state != IDLE).

Optional Feature:
- Macro: TRNG_SEQ_NUM_EN.
- Defined:
  - The collector fills only DATA_WIDTH-8 bits (data_o[DATA_WIDTH-9:0]).
  - LOAD writes data_o[DATA_WIDTH-1:DATA_WIDTH-8] = frame_cnt[7:0], the number of the frame being launched.
  - The full threshold is DATA_WIDTH-8 bits.
- Undefined: all DATA_WIDTH bits are random and there is no sequence field.

Test Plan:
- Reset, enable=1, feed 96 valid bits with pattern bit i = i[0]. Expect: `start` pulses once 3 cycles after the last bit; data_o=0xAAAA_AAAA_AAAA_AAAA_AAAA_AAAA. Return `finish` 1000 cycles later; expect frame_cnt=1, and busy falls 16 cycles after `finish`.
- Continuous rnd_valid=1 for 400 cycles with `finish` returned 200 cycles after each `start`. Expect: data_o stable between start and finish; the second frame holds bits captured from the LOAD cycle onward; drop_cnt equals the count of bits arriving while the collector is full.
- `start` issued, `finish` never returned. Expect: timeout_err=1 at 4096 cycles after START; frame_cnt unchanged; FSM returns to IDLE after GAP; next frame launches normally.
- Assert rst_n=0 for one cycle mid-WAIT with 50 bits collected. Expect: all outputs 0 on the next cycle and ccnt=0; a spurious `finish` afterwards has no effect.
- Drop enable while in WAIT with 40 bits collected. Expect: `finish` is accepted and frame_cnt++; no further `start` is issued; re-enable and 56 more bits produce the next `start`.
- With TRNG_SEQ_NUM_EN defined: after 88 bits, expect data_o[95:88]=0x00 on the first frame and 0x01 on the second.
